debug_loader: RTL and testbench
===============================

Name: debug_loader

Overview:
- UART-side program loader; receive-direction counterpart of the debug dump unit.
- Accepts a load command plus a byte stream from the UART receiver and assembles little-endian 32-bit words (byte 0 in bits [7:0], the same LSB-first order the dump unit transmits).
- Writes each word into instruction memory while holding the CPU in reset, then returns a one-byte status through the UART transmitter.

Parameters:
- ADDR_W, 10, instruction-memory word-address width.
- MAX_WORDS, 1024, largest word count accepted (must be <= 2**ADDR_W).
- TIMEOUT_CYC, 50000, idle top_clk cycles allowed between received bytes before abort.

Ports:
- top_clk  in  1  system clock, rising edge.
- top_rst_n  in  1  asynchronous active-low reset.
- rx_done_tick  in  1  one-cycle strobe: rx_bus holds a new byte.
- rx_bus  in  8  received byte.
- tx_done_tick  in  1  one-cycle strobe: transmitter finished the current byte.
- tx_start  out  1  one-cycle request to send tx_bus.
- tx_bus  out  8  status byte to send.
- mem_we  out  1  instruction-memory write strobe, one cycle per word.
- mem_addr  out  ADDR_W  word address.
- mem_wdata  out  32  assembled word.
- cpu_hold  out  1  holds the CPU in reset while a load is in progress.
- load_done  out  1  sticky; set after a successful load, cleared when the next 'l' is accepted.

Behaviour:
- Reset (async, top_rst_n=0): state=IDLE; tx_start, mem_we, cpu_hold, load_done=0; mem_addr, mem_wdata, tx_bus, byte index, word count, timeout counter=0. Reset mid-load abandons the load; no status byte is sent.
- States: IDLE, LEN_LO, LEN_HI, DATA, ACK_SEND, ACK_WAIT.
- IDLE:
  - rx_done_tick with rx_bus=0x6C ('l') -> LEN_LO; cpu_hold<=1, load_done<=0, mem_addr<=0, byte index<=0.
  - Any other byte is ignored.
- LEN_LO / LEN_HI:
  - Capture a 16-bit word count N, low byte first.
  - On the LEN_HI byte:
    - N=0 -> ACK_SEND with status 'K'.
    - N>MAX_WORDS -> ACK_SEND with status 'E'.
    - Otherwise -> DATA.
- DATA:
  - Each rx_done_tick shifts the byte into the word; byte index counts 0..3 and wraps.
  - On byte index 3: mem_wdata={b3,b2,b1,b0}; mem_we=1 for exactly the next cycle with the current mem_addr; mem_addr increments the cycle after the write.
  - After word N is written -> ACK_SEND with status 'K' (or the checksum stage, see Optional Feature).
- Timeout: in LEN_LO, LEN_HI and DATA, the counter resets on every rx_done_tick. Reaching TIMEOUT_CYC -> ACK_SEND with status 'E'. Words already written stay in memory.
- ACK_SEND: tx_bus<=status; tx_start=1 for one cycle -> ACK_WAIT.
- ACK_WAIT:
  - On tx_done_tick: cpu_hold<=0; load_done<=1 only if status was 'K'; -> IDLE.
  - rx_done_tick is ignored throughout ACK_SEND and ACK_WAIT.
- Outside ACK_SEND, tx_start=0. tx_bus holds its last value.
- mem_addr never wraps within a load, since N<=MAX_WORDS.
- Simultaneous rx_done_tick and timeout expiry: the byte wins and the counter resets.

Optional Feature:
- Macro LOADER_CHECKSUM_EN.
- Defined:
  - After word N, one extra state CHK waits for a checksum byte (the timeout still applies).
  - Status is 'K' if the byte equals the XOR of all data bytes, else 'E'.
  - N=0 also expects a checksum byte, which must be 0x00.
- Undefined: no CHK state; status after data is always 'K'.

Test Plan:
- Reset mid-DATA (top_rst_n low for 1 cycle) -> all outputs 0, state IDLE, no tx_start; a fresh 'l' load then succeeds.
- Bytes 0x6C,0x02,0x00,0x78,0x56,0x34,0x12,0xEF,0xBE,0xAD,0xDE -> mem_we at addr 0 data 0x12345678, addr 1 data 0xDEADBEEF; tx_bus='K' with a single tx_start; load_done=1 and cpu_hold=0 after tx_done_tick.
- Bytes 0x6C,0x01,0x08 (N=2049 > 1024) -> no mem_we; tx_bus='E'; load_done=0.
- 0x6C, N=1, then 2 data bytes and silence for 50000 cycles -> tx_bus='E'; no mem_we; cpu_hold released after tx_done_tick.
- Idle bytes 's','c',0x00 before 'l' -> ignored; 'l' with N=0 -> immediate 'K' (macro off).
- LOADER_CHECKSUM_EN: N=1, data 0x01,0x02,0x04,0x08, checksum 0x0F -> 'K'; the same load with checksum 0x0E -> 'E', word still written.

Source files
------------

// File: rtl/debug_loader.sv
// UART-side program loader: 'l' + 16-bit word count + little-endian words -> instruction memory.
// Optional LOADER_CHECKSUM_EN adds a trailing XOR checksum byte after the data.
module debug_loader #(
    parameter int ADDR_W      = 10,
    parameter int MAX_WORDS   = 1024,
    parameter int TIMEOUT_CYC = 50000
) (
    input  logic              top_clk,
    input  logic              top_rst_n,
    input  logic              rx_done_tick,
    input  logic [7:0]        rx_bus,
    input  logic              tx_done_tick,
    output logic              tx_start,
    output logic [7:0]        tx_bus,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic              cpu_hold,
    output logic              load_done
);

    localparam int TMO_W = $clog2(TIMEOUT_CYC + 1);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYC - 1);
    localparam logic [16:0] MAX_N = 17'(MAX_WORDS);
    localparam logic [7:0] CMD_LOAD = 8'h6C;
    localparam logic [7:0] ST_OK    = 8'h4B;
    localparam logic [7:0] ST_ERR   = 8'h45;

    typedef enum logic [2:0] {
        IDLE,
        LEN_LO,
        LEN_HI,
        DATA,
`ifdef LOADER_CHECKSUM_EN
        CHK,
`endif
        ACK_SEND,
        ACK_WAIT
    } state_t;

    state_t             state_q, state_d;
    logic [15:0]        len_q, len_d;
    logic [15:0]        word_cnt_q, word_cnt_d;
    logic [1:0]         byte_idx_q, byte_idx_d;
    logic [23:0]        shift_q, shift_d;
    logic [7:0]         xor_q, xor_d;
    logic [TMO_W-1:0]   tmo_q, tmo_d;
    logic               mem_we_q, mem_we_d;
    logic [ADDR_W-1:0]  mem_addr_q, mem_addr_d;
    logic [31:0]        mem_wdata_q, mem_wdata_d;
    logic [7:0]         tx_bus_q, tx_bus_d;
    logic               cpu_hold_q, cpu_hold_d;
    logic               load_done_q, load_done_d;

    logic               timed_state;
    logic               expired;
    logic               ack_go;
    logic [7:0]         ack_status;
    logic [15:0]        len_new;

    always_ff @(posedge top_clk or negedge top_rst_n) begin
        if (!top_rst_n) begin
            state_q     <= IDLE;
            len_q       <= '0;
            word_cnt_q  <= '0;
            byte_idx_q  <= '0;
            shift_q     <= '0;
            xor_q       <= '0;
            tmo_q       <= '0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            tx_bus_q    <= '0;
            cpu_hold_q  <= 1'b0;
            load_done_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            len_q       <= len_d;
            word_cnt_q  <= word_cnt_d;
            byte_idx_q  <= byte_idx_d;
            shift_q     <= shift_d;
            xor_q       <= xor_d;
            tmo_q       <= tmo_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            tx_bus_q    <= tx_bus_d;
            cpu_hold_q  <= cpu_hold_d;
            load_done_q <= load_done_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        len_d       = len_q;
        word_cnt_d  = word_cnt_q;
        byte_idx_d  = byte_idx_q;
        shift_d     = shift_q;
        xor_d       = xor_q;
        tmo_d       = tmo_q;
        mem_we_d    = 1'b0;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        tx_bus_d    = tx_bus_q;
        cpu_hold_d  = cpu_hold_q;
        load_done_d = load_done_q;
        ack_go      = 1'b0;
        ack_status  = ST_OK;
        len_new     = {rx_bus, len_q[7:0]};

        // Address advances the cycle after the write strobe, so the strobe sees the old address.
        if (mem_we_q) begin
            mem_addr_d = mem_addr_q + 1'b1;
        end

        timed_state = (state_q == LEN_LO) || (state_q == LEN_HI) || (state_q == DATA)
`ifdef LOADER_CHECKSUM_EN
                      || (state_q == CHK)
`endif
                      ;
        // A byte arriving on the expiry cycle wins over the timeout.
        expired = timed_state && !rx_done_tick && (tmo_q == TMO_LAST);
        if (timed_state) begin
            tmo_d = rx_done_tick ? '0 : tmo_q + 1'b1;
        end

        case (state_q)
            IDLE: begin
                if (rx_done_tick && rx_bus == CMD_LOAD) begin
                    state_d     = LEN_LO;
                    cpu_hold_d  = 1'b1;
                    load_done_d = 1'b0;
                    mem_addr_d  = '0;
                    byte_idx_d  = '0;
                    word_cnt_d  = '0;
                    xor_d       = '0;
                    tmo_d       = '0;
                end
            end
            LEN_LO: begin
                if (rx_done_tick) begin
                    len_d[7:0] = rx_bus;
                    state_d    = LEN_HI;
                end
            end
            LEN_HI: begin
                if (rx_done_tick) begin
                    len_d = len_new;
                    if (len_new == 16'd0) begin
`ifdef LOADER_CHECKSUM_EN
                        state_d = CHK;
`else
                        ack_go     = 1'b1;
                        ack_status = ST_OK;
`endif
                    end else if ({1'b0, len_new} > MAX_N) begin
                        ack_go     = 1'b1;
                        ack_status = ST_ERR;
                    end else begin
                        state_d = DATA;
                    end
                end
            end
            DATA: begin
                if (rx_done_tick) begin
                    xor_d      = xor_q ^ rx_bus;
                    byte_idx_d = byte_idx_q + 1'b1;
                    shift_d    = {rx_bus, shift_q[23:8]};
                    if (byte_idx_q == 2'd3) begin
                        mem_wdata_d = {rx_bus, shift_q};
                        mem_we_d    = 1'b1;
                        word_cnt_d  = word_cnt_q + 1'b1;
                        if (word_cnt_q + 16'd1 == len_q) begin
`ifdef LOADER_CHECKSUM_EN
                            state_d = CHK;
`else
                            ack_go     = 1'b1;
                            ack_status = ST_OK;
`endif
                        end
                    end
                end
            end
`ifdef LOADER_CHECKSUM_EN
            CHK: begin
                if (rx_done_tick) begin
                    ack_go     = 1'b1;
                    ack_status = (rx_bus == xor_q) ? ST_OK : ST_ERR;
                end
            end
`endif
            ACK_SEND: begin
                state_d = ACK_WAIT;
            end
            ACK_WAIT: begin
                if (tx_done_tick) begin
                    cpu_hold_d  = 1'b0;
                    load_done_d = (tx_bus_q == ST_OK);
                    state_d     = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (expired) begin
            ack_go     = 1'b1;
            ack_status = ST_ERR;
        end
        // Status byte is loaded on entry so it is stable while tx_start is high.
        if (ack_go) begin
            state_d  = ACK_SEND;
            tx_bus_d = ack_status;
        end
    end

    assign tx_start  = (state_q == ACK_SEND);
    assign tx_bus    = tx_bus_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign cpu_hold  = cpu_hold_q;
    assign load_done = load_done_q;

endmodule

// File: tb/tb_debug_loader.sv
// Directed testbench for debug_loader; checksum scenarios build when LOADER_CHECKSUM_EN is defined.
module tb_debug_loader;

    logic        top_clk = 1'b0;
    logic        top_rst_n = 1'b0;
    logic        rx_done_tick = 1'b0;
    logic [7:0]  rx_bus = 8'h00;
    logic        tx_done_tick = 1'b0;
    logic        tx_start;
    logic [7:0]  tx_bus;
    logic        mem_we;
    logic [9:0]  mem_addr;
    logic [31:0] mem_wdata;
    logic        cpu_hold;
    logic        load_done;

    int pass_cnt = 0;
    int total_cnt = 0;

    int          we_cnt = 0;
    int          tx_cnt = 0;
    logic [9:0]  we_addr [0:63];
    logic [31:0] we_data [0:63];
    logic [7:0]  tx_last = 8'h00;

    always #5 top_clk = ~top_clk;

    debug_loader dut (
        .top_clk      (top_clk),
        .top_rst_n    (top_rst_n),
        .rx_done_tick (rx_done_tick),
        .rx_bus       (rx_bus),
        .tx_done_tick (tx_done_tick),
        .tx_start     (tx_start),
        .tx_bus       (tx_bus),
        .mem_we       (mem_we),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .cpu_hold     (cpu_hold),
        .load_done    (load_done)
    );

    always @(negedge top_clk) begin
        if (mem_we) begin
            we_addr[we_cnt % 64] = mem_addr;
            we_data[we_cnt % 64] = mem_wdata;
            we_cnt++;
        end
        if (tx_start) begin
            tx_last = tx_bus;
            tx_cnt++;
        end
    end

    task automatic send_byte(input logic [7:0] b);
        @(negedge top_clk);
        rx_bus = b;
        rx_done_tick = 1'b1;
        @(negedge top_clk);
        rx_done_tick = 1'b0;
        @(negedge top_clk);
    endtask

    // Waits (bounded) for a tx_start, then answers with tx_done_tick.
    task automatic wait_ack(input int limit, input int base, output bit found, output logic [7:0] b);
        found = 1'b0;
        b = 8'h00;
        for (int i = 0; i < limit && !found; i++) begin
            @(negedge top_clk);
            if (tx_cnt != base) found = 1'b1;
        end
        if (found) begin
            b = tx_last;
            repeat (3) @(negedge top_clk);
            tx_done_tick = 1'b1;
            @(negedge top_clk);
            tx_done_tick = 1'b0;
            repeat (2) @(negedge top_clk);
        end
    endtask

    task automatic test_reset();
        top_rst_n = 1'b0;
        repeat (3) @(negedge top_clk);
        total_cnt++;
        if ({tx_start, mem_we, cpu_hold, load_done} !== 4'b0000 || mem_addr !== 10'd0 ||
            mem_wdata !== 32'd0 || tx_bus !== 8'd0)
            $display("FAIL reset_state: outs=%b addr=%h wdata=%h tx_bus=%h, required all zero",
                     {tx_start, mem_we, cpu_hold, load_done}, mem_addr, mem_wdata, tx_bus);
        else pass_cnt++;
        top_rst_n = 1'b1;
        repeat (2) @(negedge top_clk);
    endtask

    task automatic test_two_words();
        logic [7:0] seq [0:10] = '{8'h6C, 8'h02, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12,
                                   8'hEF, 8'hBE, 8'hAD, 8'hDE};
        int wb, tb_;
        bit found;
        logic [7:0] st;
        wb = we_cnt;
        tb_ = tx_cnt;
        for (int i = 0; i < 11; i++) begin
            send_byte(seq[i]);
            if (i == 0) begin
                total_cnt++;
                if (cpu_hold !== 1'b1) $display("FAIL two_words_hold: cpu_hold=%b required 1", cpu_hold);
                else pass_cnt++;
            end
        end
`ifdef LOADER_CHECKSUM_EN
        send_byte(8'h2A);
`endif
        wait_ack(200, tb_, found, st);
        total_cnt++;
        if (we_cnt - wb !== 2) $display("FAIL two_words_we_count: got %0d required 2", we_cnt - wb);
        else pass_cnt++;
        total_cnt++;
        if (we_addr[wb % 64] !== 10'd0 || we_data[wb % 64] !== 32'h12345678)
            $display("FAIL two_words_w0: addr=%h data=%h required 000/12345678", we_addr[wb % 64], we_data[wb % 64]);
        else pass_cnt++;
        total_cnt++;
        if (we_addr[(wb + 1) % 64] !== 10'd1 || we_data[(wb + 1) % 64] !== 32'hDEADBEEF)
            $display("FAIL two_words_w1: addr=%h data=%h required 001/deadbeef",
                     we_addr[(wb + 1) % 64], we_data[(wb + 1) % 64]);
        else pass_cnt++;
        total_cnt++;
        if (!found || st !== 8'h4B || tx_cnt - tb_ !== 1)
            $display("FAIL two_words_ack: found=%0d status=%h starts=%0d required 1/4b/1", found, st, tx_cnt - tb_);
        else pass_cnt++;
        total_cnt++;
        if (load_done !== 1'b1 || cpu_hold !== 1'b0)
            $display("FAIL two_words_done: load_done=%b cpu_hold=%b required 1/0", load_done, cpu_hold);
        else pass_cnt++;
    endtask

    task automatic test_reset_mid_data();
        int wb, tb_;
        bit found;
        logic [7:0] st;
        logic [7:0] w [0:3] = '{8'hA1, 8'hB2, 8'hC3, 8'hD4};
        send_byte(8'h6C);
        send_byte(8'h01);
        send_byte(8'h00);
        send_byte(8'h11);
        send_byte(8'h22);
        tb_ = tx_cnt;
        top_rst_n = 1'b0;
        @(negedge top_clk);
        total_cnt++;
        if ({tx_start, mem_we, cpu_hold, load_done} !== 4'b0000 || mem_addr !== 10'd0 ||
            mem_wdata !== 32'd0 || tx_bus !== 8'd0)
            $display("FAIL mid_reset_state: outs=%b addr=%h wdata=%h tx_bus=%h, required all zero",
                     {tx_start, mem_we, cpu_hold, load_done}, mem_addr, mem_wdata, tx_bus);
        else pass_cnt++;
        top_rst_n = 1'b1;
        repeat (20) @(negedge top_clk);
        total_cnt++;
        if (tx_cnt !== tb_ || cpu_hold !== 1'b0)
            $display("FAIL mid_reset_quiet: starts=%0d cpu_hold=%b required 0/0", tx_cnt - tb_, cpu_hold);
        else pass_cnt++;
        // A stray data byte must be ignored in IDLE, then a fresh one-word load succeeds.
        wb = we_cnt;
        send_byte(8'h33);
        send_byte(8'h6C);
        send_byte(8'h01);
        send_byte(8'h00);
        for (int i = 0; i < 4; i++) send_byte(w[i]);
`ifdef LOADER_CHECKSUM_EN
        send_byte(8'hA1 ^ 8'hB2 ^ 8'hC3 ^ 8'hD4);
`endif
        wait_ack(200, tb_, found, st);
        total_cnt++;
        if (we_cnt - wb !== 1 || we_addr[wb % 64] !== 10'd0 || we_data[wb % 64] !== 32'hD4C3B2A1)
            $display("FAIL mid_reset_reload_word: writes=%0d addr=%h data=%h required 1/000/d4c3b2a1",
                     we_cnt - wb, we_addr[wb % 64], we_data[wb % 64]);
        else pass_cnt++;
        total_cnt++;
        if (!found || st !== 8'h4B || load_done !== 1'b1)
            $display("FAIL mid_reset_reload_ack: found=%0d status=%h load_done=%b required 1/4b/1", found, st, load_done);
        else pass_cnt++;
    endtask

    task automatic test_too_long();
        int wb, tb_;
        bit found;
        logic [7:0] st;
        wb = we_cnt;
        tb_ = tx_cnt;
        send_byte(8'h6C);
        send_byte(8'h01);
        send_byte(8'h08);
        wait_ack(50, tb_, found, st);
        total_cnt++;
        if (!found || st !== 8'h45) $display("FAIL too_long_status: found=%0d status=%h required 1/45", found, st);
        else pass_cnt++;
        total_cnt++;
        if (we_cnt !== wb || load_done !== 1'b0 || cpu_hold !== 1'b0)
            $display("FAIL too_long_side: writes=%0d load_done=%b cpu_hold=%b required 0/0/0",
                     we_cnt - wb, load_done, cpu_hold);
        else pass_cnt++;
    endtask

    task automatic test_max_words_ok();
        // N=1024 is exactly the limit and must enter DATA, not error; abandon by reset afterwards.
        int tb_;
        tb_ = tx_cnt;
        send_byte(8'h6C);
        send_byte(8'h00);
        send_byte(8'h04);
        repeat (20) @(negedge top_clk);
        total_cnt++;
        if (tx_cnt !== tb_ || cpu_hold !== 1'b1)
            $display("FAIL max_words_accept: starts=%0d cpu_hold=%b required 0/1", tx_cnt - tb_, cpu_hold);
        else pass_cnt++;
        top_rst_n = 1'b0;
        @(negedge top_clk);
        top_rst_n = 1'b1;
        @(negedge top_clk);
    endtask

    task automatic test_timeout();
        int wb, tb_;
        bit found;
        logic [7:0] st;
        wb = we_cnt;
        tb_ = tx_cnt;
        send_byte(8'h6C);
        send_byte(8'h01);
        send_byte(8'h00);
        send_byte(8'h55);
        send_byte(8'h66);
        repeat (40000) @(negedge top_clk);
        total_cnt++;
        if (tx_cnt !== tb_ || cpu_hold !== 1'b1)
            $display("FAIL timeout_early: starts=%0d cpu_hold=%b required 0/1", tx_cnt - tb_, cpu_hold);
        else pass_cnt++;
        wait_ack(15000, tb_, found, st);
        total_cnt++;
        if (!found || st !== 8'h45) $display("FAIL timeout_status: found=%0d status=%h required 1/45", found, st);
        else pass_cnt++;
        total_cnt++;
        if (we_cnt !== wb || cpu_hold !== 1'b0 || load_done !== 1'b0)
            $display("FAIL timeout_side: writes=%0d cpu_hold=%b load_done=%b required 0/0/0",
                     we_cnt - wb, cpu_hold, load_done);
        else pass_cnt++;
    endtask

    task automatic test_idle_zero();
        int wb, tb_;
        bit found;
        logic [7:0] st;
        wb = we_cnt;
        tb_ = tx_cnt;
        send_byte(8'h73);
        send_byte(8'h63);
        send_byte(8'h00);
        total_cnt++;
        if (cpu_hold !== 1'b0 || tx_cnt !== tb_)
            $display("FAIL idle_ignore: cpu_hold=%b starts=%0d required 0/0", cpu_hold, tx_cnt - tb_);
        else pass_cnt++;
        send_byte(8'h6C);
        send_byte(8'h00);
        send_byte(8'h00);
`ifdef LOADER_CHECKSUM_EN
        send_byte(8'h00);
`endif
        wait_ack(50, tb_, found, st);
        total_cnt++;
        if (!found || st !== 8'h4B || load_done !== 1'b1 || we_cnt !== wb)
            $display("FAIL zero_len: found=%0d status=%h load_done=%b writes=%0d required 1/4b/1/0",
                     found, st, load_done, we_cnt - wb);
        else pass_cnt++;
    endtask

`ifdef LOADER_CHECKSUM_EN
    task automatic test_checksum();
        logic [7:0] chk [0:1] = '{8'h0F, 8'h0E};
        logic [7:0] exp_st [0:1] = '{8'h4B, 8'h45};
        int wb, tb_;
        bit found;
        logic [7:0] st;
        for (int k = 0; k < 2; k++) begin
            wb = we_cnt;
            tb_ = tx_cnt;
            send_byte(8'h6C);
            send_byte(8'h01);
            send_byte(8'h00);
            send_byte(8'h01);
            send_byte(8'h02);
            send_byte(8'h04);
            send_byte(8'h08);
            send_byte(chk[k]);
            wait_ack(50, tb_, found, st);
            total_cnt++;
            if (!found || st !== exp_st[k] || load_done !== (k == 0))
                $display("FAIL checksum_%0d: found=%0d status=%h load_done=%b required 1/%h/%0d",
                         k, found, st, load_done, exp_st[k], k == 0);
            else pass_cnt++;
            total_cnt++;
            if (we_cnt - wb !== 1 || we_data[wb % 64] !== 32'h08040201)
                $display("FAIL checksum_word_%0d: writes=%0d data=%h required 1/08040201",
                         k, we_cnt - wb, we_data[wb % 64]);
            else pass_cnt++;
        end
    endtask
`endif

    initial begin
        test_reset();
        test_two_words();
        test_reset_mid_data();
        test_too_long();
        test_max_words_ok();
        test_timeout();
        test_idle_zero();
`ifdef LOADER_CHECKSUM_EN
        test_checksum();
`endif
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
